prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/prefetch_unit.sv | 139 +++++++++++++
 tb/tb_prefetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch path.
// Holds the fetch entry bundle passed from prefetch to decode.
package fetch_pkg;

    localparam int XLEN            = 32;
    localparam int MAX_OUTSTANDING = 2;
    localparam int PC_INC          = 4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered FIFO of fetch entries, DEPTH a power of two.
// Ports: clk, rst (async low), flush, push/din, pop/dout, full, empty, count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        din,
    input  logic          pop,
    output entry_t        dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        // a full FIFO still accepts a write when the head leaves this cycle
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: issues sequential fetches, buffers responses for decode,
// squashes in-flight responses on an execute-stage redirect.
// Ports: clk, rst (async low), PCsrc_E/PCTarget_E redirect,
//   imem_req/imem_addr/imem_gnt request, imem_rvalid/imem_rdata response,
//   valid_F/ready_D handshake, instr_F/PC_F/PCPlus4_F head entry.
// Option: define PREFETCH_BYPASS_EN to forward a response straight to
//   the outputs when the buffer is empty.
module prefetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCsrc_E,
    input  logic [WIDTH-1:0] PCTarget_E,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             valid_F,
    input  logic             ready_D,
    output logic [WIDTH-1:0] instr_F,
    output logic [WIDTH-1:0] PC_F,
    output logic [WIDTH-1:0] PCPlus4_F
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] pc_q;
    logic [1:0]       out_q;
    logic [1:0]       drop_q;
    logic [WIDTH-1:0] aq [2];
    logic             aq_wp;
    logic             aq_rp;

    logic             issue;
    logic             resp;
    logic             resp_drop;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      inflight;
    fetch_entry_t     resp_ent;
    fetch_entry_t     fifo_dout;
    fetch_entry_t     head;

    always_comb begin
        inflight  = (CW+1)'(out_q) + (CW+1)'(fifo_count);
        // gating with rst keeps the request low throughout reset
        imem_req  = rst && !PCsrc_E && !fifo_full
                 && (out_q < 2'(MAX_OUTSTANDING))
                 && (inflight < (CW+1)'(DEPTH));
        imem_addr = pc_q;
        issue     = imem_req && imem_gnt;
        // a response with nothing outstanding cannot be ours
        resp      = imem_rvalid && (out_q != '0);
        resp_drop = PCsrc_E || (drop_q != '0);

        resp_ent.instr    = XLEN'(imem_rdata);
        resp_ent.pc       = XLEN'(aq[aq_rp]);
        resp_ent.pc_plus4 = XLEN'(aq[aq_rp] + WIDTH'(PC_INC));

`ifdef PREFETCH_BYPASS_EN
        if (fifo_empty && resp && !resp_drop) begin
            head    = resp_ent;
            valid_F = 1'b1;
            push    = !ready_D;
        end else begin
            head    = fifo_dout;
            valid_F = !fifo_empty;
            push    = resp && !resp_drop;
        end
`else
        head    = fifo_dout;
        valid_F = !fifo_empty;
        push    = resp && !resp_drop;
`endif

        pop       = valid_F && ready_D && !PCsrc_E;
        instr_F   = WIDTH'(head.instr);
        PC_F      = WIDTH'(head.pc);
        PCPlus4_F = WIDTH'(head.pc_plus4);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
            aq_wp  <= 1'b0;
            aq_rp  <= 1'b0;
            aq[0]  <= '0;
            aq[1]  <= '0;
        end else begin
            if (PCsrc_E) begin
                pc_q <= PCTarget_E;
            end else if (issue) begin
                pc_q <= pc_q + WIDTH'(PC_INC);
            end
            out_q <= out_q + 2'(issue) - 2'(resp);
            if (issue) begin
                aq[aq_wp] <= pc_q;
                aq_wp     <= ~aq_wp;
            end
            // address queue pops on every response, squashed or not
            if (resp) begin
                aq_rp <= ~aq_rp;
            end
            if (PCsrc_E) begin
                drop_q <= out_q - 2'(resp);
            end else if (resp && drop_q != '0) begin
                drop_q <= drop_q - 2'd1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (PCsrc_E),
        .push  (push),
        .din   (resp_ent),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: directed vectors and redirect/wrap/bypass sequences
// against a latency-1 in-order instruction memory model.
module tb_prefetch_unit;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        PCsrc_E    = 1'b0;
    logic [31:0] PCTarget_E = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_F;
    logic        ready_D    = 1'b0;
    logic [31:0] instr_F;
    logic [31:0] PC_F;
    logic [31:0] PCPlus4_F;

    logic        resp_en     = 1'b1;
    logic        data_ovr_en = 1'b0;
    logic [31:0] data_ovr    = '0;
    logic [31:0] mq [0:1];
    int          mq_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prefetch_unit #(
        .WIDTH    (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCsrc_E     (PCsrc_E),
        .PCTarget_E  (PCTarget_E),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid_F     (valid_F),
        .ready_D     (ready_D),
        .instr_F     (instr_F),
        .PC_F        (PC_F),
        .PCPlus4_F   (PCPlus4_F)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 8) + 32'h0000_0013;
    endfunction

    assign imem_gnt    = 1'b1;
    assign imem_rvalid = resp_en && (mq_n > 0);
    assign imem_rdata  = data_ovr_en ? data_ovr : mem_word(mq[0]);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq_n <= 0;
        end else begin
            case ({imem_rvalid, imem_req && imem_gnt})
                2'b01: begin
                    if (mq_n == 0) mq[0] <= imem_addr;
                    else           mq[1] <= imem_addr;
                    mq_n <= mq_n + 1;
                end
                2'b10: begin
                    mq[0] <= mq[1];
                    mq_n  <= mq_n - 1;
                end
                2'b11: begin
                    if (mq_n == 1) begin
                        mq[0] <= imem_addr;
                    end else begin
                        mq[0] <= mq[1];
                        mq[1] <= imem_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, " valid_F"}, valid_F, 1);
        chk({tag, " PC_F"}, PC_F, pc);
        chk({tag, " PCPlus4_F"}, PCPlus4_F, pc + 32'd4);
        chk({tag, " instr_F"}, instr_F, mem_word(pc));
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        PCsrc_E     = 1'b0;
        resp_en     = 1'b1;
        data_ovr_en = 1'b0;
        ready_D     = 1'b0;
        #1;
        chk("rst valid_F", valid_F, 0);
        chk("rst imem_req", imem_req, 0);
        chk("rst instr_F", instr_F, 0);
        chk("rst PC_F", PC_F, 0);
        chk("rst PCPlus4_F", PCPlus4_F, 0);
        next();
        next();
        rst = 1'b1;
    endtask

    typedef struct {
        bit          rst_before;
        bit          ready;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vt [14];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // streaming, decode always ready
        vt[0]  = '{1, 1, 1, 32'h00, 0, 32'h0};
        vt[1]  = '{0, 1, 1, 32'h04, 0, 32'h0};
        vt[2]  = '{0, 1, 1, 32'h08, 1, 32'h0};
        vt[3]  = '{0, 1, 1, 32'h0C, 1, 32'h4};
        vt[4]  = '{0, 1, 1, 32'h10, 1, 32'h8};
        vt[5]  = '{0, 1, 1, 32'h14, 1, 32'hC};
        // decode stalled: buffer fills, requests stop, head holds
        vt[6]  = '{1, 0, 1, 32'h00, 0, 32'h0};
        vt[7]  = '{0, 0, 1, 32'h04, 0, 32'h0};
        vt[8]  = '{0, 0, 1, 32'h08, 1, 32'h0};
        vt[9]  = '{0, 0, 1, 32'h0C, 1, 32'h0};
        vt[10] = '{0, 0, 0, 32'h00, 1, 32'h0};
        vt[11] = '{0, 0, 0, 32'h00, 1, 32'h0};
        vt[12] = '{0, 1, 0, 32'h00, 1, 32'h0};
        vt[13] = '{0, 1, 1, 32'h10, 1, 32'h4};

        #2;
        for (int i = 0; i < 14; i++) begin
            if (vt[i].rst_before) do_reset();
            ready_D = vt[i].ready;
            #1;
            chk($sformatf("v%0d imem_req", i), imem_req, vt[i].req);
            if (vt[i].req)
                chk($sformatf("v%0d imem_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("v%0d valid_F", i), valid_F, vt[i].valid);
            if (vt[i].valid)
                chk_head($sformatf("v%0d", i), vt[i].pc);
            next();
        end

        // redirect with two requests outstanding
        do_reset();
        ready_D = 1'b1;
        resp_en = 1'b0;
        #1; chk("rd c0 addr", imem_addr, 32'h0); next();
        #1; chk("rd c1 addr", imem_addr, 32'h4); next();
        PCsrc_E = 1'b1; PCTarget_E = 32'h100;
        #1; chk("rd c2 imem_req", imem_req, 0); next();
        PCsrc_E = 1'b0; resp_en = 1'b1;
        #1; chk("rd c3 valid_F", valid_F, 0);
        chk("rd c3 imem_req", imem_req, 0); next();
        #1; chk("rd c4 valid_F", valid_F, 0);
        chk("rd c4 imem_req", imem_req, 1);
        chk("rd c4 addr", imem_addr, 32'h100); next();
        #1; chk("rd c5 valid_F", valid_F, 0);
        chk("rd c5 addr", imem_addr, 32'h104); next();
        #1; chk_head("rd c6", 32'h100);
        next();

        // redirect colliding with a response, pop and near-full buffer
        do_reset();
        ready_D = 1'b0;
        #1; next(); next(); next(); next();
        PCsrc_E = 1'b1; PCTarget_E = 32'h200; ready_D = 1'b1;
        #1; chk("rf c4 rvalid", imem_rvalid, 1);
        chk("rf c4 PC_F", PC_F, 32'h0);
        chk("rf c4 imem_req", imem_req, 0); next();
        PCsrc_E = 1'b0;
        #1; chk("rf c5 valid_F", valid_F, 0);
        chk("rf c5 addr", imem_addr, 32'h200); next();
        #1; chk("rf c6 valid_F", valid_F, 0); next();
        #1; chk_head("rf c7", 32'h200);
        next();

        // idle redirect then PC wrap
        do_reset();
        ready_D = 1'b1;
        PCsrc_E = 1'b1; PCTarget_E = 32'hFFFF_FFFC;
        #1; chk("wr c0 imem_req", imem_req, 0); next();
        PCsrc_E = 1'b0;
        #1; chk("wr c1 addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr c1 valid_F", valid_F, 0); next();
        #1; chk("wr c2 addr", imem_addr, 32'h0); next();
        #1; chk_head("wr c3", 32'hFFFF_FFFC);
        chk("wr c3 PCPlus4_F", PCPlus4_F, 32'h0); next();
        #1; chk_head("wr c4", 32'h0);
        next();

        // first response with an empty buffer
        do_reset();
        ready_D = 1'b0;
        data_ovr_en = 1'b1; data_ovr = 32'h00A0_0513;
        #1; next();
        #1;
`ifdef PREFETCH_BYPASS_EN
        chk("bp c1 valid_F", valid_F, 1);
        chk("bp c1 instr_F", instr_F, 32'h00A0_0513);
`else
        chk("bp c1 valid_F", valid_F, 0);
`endif
        next();
        #1; chk("bp c2 valid_F", valid_F, 1);
        chk("bp c2 instr_F", instr_F, 32'h00A0_0513);
        chk("bp c2 PC_F", PC_F, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
